// File: rtl/osd_msg_source_pkg.sv
// -----------------------------------------------------------------------------
// osd_msg_source_pkg
// Shared types and elaboration-time helpers for the debug message source.
//   msg_src_state_t : FSM state encoding (IDLE, SEND, CGAP, MGAP, DONE)
//   gap_cnt_width() : width of the inter-character / inter-message gap counter
//   idx_width()     : width of the character index register
// -----------------------------------------------------------------------------
package osd_msg_source_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_CGAP = 3'd2,
        ST_MGAP = 3'd3,
        ST_DONE = 3'd4
    } msg_src_state_t;

    // Enough bits to hold max(char_gap, msg_gap); never narrower than one bit.
    function automatic int gap_cnt_width(input int char_gap, input int msg_gap);
        int max_gap;
        if (char_gap > msg_gap) begin
            max_gap = char_gap;
        end else begin
            max_gap = msg_gap;
        end
        if (max_gap < 1) begin
            return 1;
        end else begin
            return $clog2(max_gap + 1);
        end
    endfunction

    // Index range is 0..msg_len-1; a one-character message still needs one bit.
    function automatic int idx_width(input int msg_len);
        if (msg_len > 1) begin
            return $clog2(msg_len);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/osd_msg_source_if.sv
// -----------------------------------------------------------------------------
// osd_msg_source_if
// Character-stream handshake between a character source and a character sink
// (for example the out_char/out_valid/out_ready side of osd_dem_uart).
//   out_char  : character presented by the source
//   out_valid : source has a character for the sink
//   out_ready : sink accepts the character this cycle
// modport master : source side (drives out_char/out_valid)
// modport slave  : sink side   (drives out_ready)
// -----------------------------------------------------------------------------
interface osd_msg_source_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] out_char;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output out_char,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_char,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/osd_msg_source.sv
// -----------------------------------------------------------------------------
// osd_msg_source
// Debug character-stream source: plays a fixed, parameter-defined message into
// a character sink REPEAT times (0 = forever) with optional idle gaps between
// characters (CHAR_GAP) and between messages (MSG_GAP).
//
// Ports:
//   clk          : clock
//   rst          : synchronous, active-high reset
//   start_i      : pulse, begins a new run from IDLE or DONE (ignored while busy)
//   abort_i      : pulse, returns to IDLE from any state (wins over start_i)
//   chr_if       : character stream (master side: out_char/out_valid, out_ready)
//   busy_o       : run in progress (SEND, CGAP or MGAP)
//   done_o       : run completed, sticky until the next start
//   msg_count_o  : messages fully sent in this run, saturating
//
// Every output is a flop; out_ready, start_i and abort_i only reach the
// outputs through the next-state logic.
// -----------------------------------------------------------------------------
module osd_msg_source
    import osd_msg_source_pkg::*;
#(
    parameter int                               DATA_WIDTH = 8,
    parameter int                               MSG_LEN    = 13,
    parameter logic [MSG_LEN*DATA_WIDTH-1:0]    MSG        = "Hello World!\n",
    parameter int                               REPEAT     = 1,
    parameter int                               CHAR_GAP   = 0,
    parameter int                               MSG_GAP    = 0,
    parameter int                               AUTOSTART  = 1,
    parameter int                               CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 abort_i,
    osd_msg_source_if.master     chr_if,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_WIDTH-1:0] msg_count_o
);

    localparam int GW = gap_cnt_width(CHAR_GAP, MSG_GAP);
    localparam int IW = idx_width(MSG_LEN);

    // A gap of N cycles is N states in CGAP/MGAP; the counter is loaded with
    // N-1 and the state leaves when it reads zero.
    localparam logic [GW-1:0] CGAP_LOAD = (CHAR_GAP > 0) ? GW'(CHAR_GAP - 1) : {GW{1'b0}};
    localparam logic [GW-1:0] MGAP_LOAD = (MSG_GAP > 0)  ? GW'(MSG_GAP - 1)  : {GW{1'b0}};

    localparam logic [IW-1:0]        LAST_IDX   = IW'(MSG_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] REPEAT_CNT = CNT_WIDTH'(REPEAT);
    localparam bit                   HAS_CGAP   = (CHAR_GAP > 0);
    localparam bit                   HAS_MGAP   = (MSG_GAP > 0);
    localparam bit                   FINITE_RUN = (REPEAT != 0);
    localparam bit                   AUTO_INIT  = (AUTOSTART != 0);

    // Character i of the message; character 0 is the most significant slice.
    function automatic logic [DATA_WIDTH-1:0] char_at(input logic [IW-1:0] i);
        logic [DATA_WIDTH-1:0] c;
        c = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < MSG_LEN; k++) begin
            c = (i == IW'(k)) ? MSG[(MSG_LEN-1-k)*DATA_WIDTH +: DATA_WIDTH] : c;
        end
        return c;
    endfunction

    msg_src_state_t        state_q,     state_d;
    logic [IW-1:0]         idx_q,       idx_d;
    logic [GW-1:0]         gap_q,       gap_d;
    logic [CNT_WIDTH-1:0]  msg_count_q, msg_count_d;
    logic                  auto_q,      auto_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_char_q,  out_char_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    logic                  xfer_s;
    logic [CNT_WIDTH-1:0]  cnt_inc_s;

    // Handshake completes when the registered valid meets the sink's ready.
    assign xfer_s    = out_valid_q & chr_if.out_ready;

    // Message counter value after one more completed message, held at all-ones.
    assign cnt_inc_s = (msg_count_q == {CNT_WIDTH{1'b1}}) ? msg_count_q
                                                         : msg_count_q + CNT_WIDTH'(1'b1);

    // Next-state, counters and decoded next outputs.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gap_d       = gap_q;
        msg_count_d = msg_count_q;
        // The autostart request lives for exactly one cycle after reset.
        auto_d      = 1'b0;

        if (abort_i) begin
            // A character accepted in this cycle is delivered, but the
            // position and count are deliberately left untouched.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i || auto_q) begin
                        state_d     = ST_SEND;
                        idx_d       = {IW{1'b0}};
                        msg_count_d = {CNT_WIDTH{1'b0}};
                    end else begin
                        state_d     = state_q;
                    end
                end
                ST_SEND: begin
                    if (xfer_s) begin
                        if (idx_q == LAST_IDX) begin
                            idx_d       = {IW{1'b0}};
                            msg_count_d = cnt_inc_s;
                            if (FINITE_RUN && (cnt_inc_s == REPEAT_CNT)) begin
                                state_d = ST_DONE;
                            end else if (HAS_MGAP) begin
                                state_d = ST_MGAP;
                                gap_d   = MGAP_LOAD;
                            end else begin
                                state_d = ST_SEND;
                            end
                        end else begin
                            idx_d = idx_q + IW'(1'b1);
                            if (HAS_CGAP) begin
                                state_d = ST_CGAP;
                                gap_d   = CGAP_LOAD;
                            end else begin
                                state_d = ST_SEND;
                            end
                        end
                    end else begin
                        state_d = ST_SEND;
                    end
                end
                ST_CGAP, ST_MGAP: begin
                    if (gap_q == {GW{1'b0}}) begin
                        state_d = ST_SEND;
                    end else begin
                        gap_d   = gap_q - GW'(1'b1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they can be registered.
        out_valid_d = (state_d == ST_SEND);
        out_char_d  = (state_d == ST_SEND) ? char_at(idx_d) : {DATA_WIDTH{1'b0}};
        busy_d      = (state_d == ST_SEND) || (state_d == ST_CGAP) || (state_d == ST_MGAP);
        done_d      = (state_d == ST_DONE);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IW{1'b0}};
            gap_q       <= {GW{1'b0}};
            msg_count_q <= {CNT_WIDTH{1'b0}};
            auto_q      <= AUTO_INIT;
            out_valid_q <= 1'b0;
            out_char_q  <= {DATA_WIDTH{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gap_q       <= gap_d;
            msg_count_q <= msg_count_d;
            auto_q      <= auto_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign chr_if.out_valid = out_valid_q;
    assign chr_if.out_char  = out_char_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign msg_count_o      = msg_count_q;

endmodule

// File: tb/tb_osd_msg_source.sv
// -----------------------------------------------------------------------------
// tb_osd_msg_source
// Directed bench for osd_msg_source using four differently parameterised
// instances, each with its own reset and control inputs:
//   a : defaults                                    (plain run, backpressure, abort)
//   b : CHAR_GAP=2, MSG_GAP=5, REPEAT=2             (gap timing, repeat, done)
//   c : REPEAT=0, MSG_LEN=1, MSG=8'h55, CNT_WIDTH=4 (endless, saturating count)
//   d : AUTOSTART=0                                 (manual start, mid-message reset)
// -----------------------------------------------------------------------------
module tb_osd_msg_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, start_a = 1'b0, abort_a = 1'b0;
    logic rst_b = 1'b1, start_b = 1'b0, abort_b = 1'b0;
    logic rst_c = 1'b1, start_c = 1'b0, abort_c = 1'b0;
    logic rst_d = 1'b1, start_d = 1'b0, abort_d = 1'b0;

    logic        busy_a, done_a, busy_b, done_b, busy_c, done_c, busy_d, done_d;
    logic [15:0] cnt_a, cnt_b, cnt_d;
    logic [3:0]  cnt_c;

    osd_msg_source_if #(.DATA_WIDTH(8)) if_a ();
    osd_msg_source_if #(.DATA_WIDTH(8)) if_b ();
    osd_msg_source_if #(.DATA_WIDTH(8)) if_c ();
    osd_msg_source_if #(.DATA_WIDTH(8)) if_d ();

    osd_msg_source dut_a (
        .clk(clk), .rst(rst_a), .start_i(start_a), .abort_i(abort_a),
        .chr_if(if_a), .busy_o(busy_a), .done_o(done_a), .msg_count_o(cnt_a)
    );

    osd_msg_source #(.CHAR_GAP(2), .MSG_GAP(5), .REPEAT(2)) dut_b (
        .clk(clk), .rst(rst_b), .start_i(start_b), .abort_i(abort_b),
        .chr_if(if_b), .busy_o(busy_b), .done_o(done_b), .msg_count_o(cnt_b)
    );

    osd_msg_source #(.MSG_LEN(1), .MSG(8'h55), .REPEAT(0), .CNT_WIDTH(4)) dut_c (
        .clk(clk), .rst(rst_c), .start_i(start_c), .abort_i(abort_c),
        .chr_if(if_c), .busy_o(busy_c), .done_o(done_c), .msg_count_o(cnt_c)
    );

    osd_msg_source #(.AUTOSTART(0)) dut_d (
        .clk(clk), .rst(rst_d), .start_i(start_d), .abort_i(abort_d),
        .chr_if(if_d), .busy_o(busy_d), .done_o(done_d), .msg_count_o(cnt_d)
    );

    // "Hello World!\n"
    logic [7:0] msg_tbl [13] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57,
                                 8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0a};

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int bad;
        int last_cyc;
        int budget;
        logic       hold_pend;
        logic [7:0] held_char;

        if_a.out_ready = 1'b1;
        if_b.out_ready = 1'b1;
        if_c.out_ready = 1'b1;
        if_d.out_ready = 1'b0;
        repeat (3) step();

        // ---------------- Test 1: reset state, then plain run --------------
        chk("a_rst_valid", 32'(if_a.out_valid), 32'd0);
        chk("a_rst_char",  32'(if_a.out_char),  32'd0);
        chk("a_rst_busy",  32'(busy_a),         32'd0);
        chk("a_rst_done",  32'(done_a),         32'd0);
        chk("a_rst_cnt",   32'(cnt_a),          32'd0);
        rst_a = 1'b0;
        step();
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("a_run_valid%0d", i), 32'(if_a.out_valid), 32'd1);
            chk($sformatf("a_run_char%0d", i),  32'(if_a.out_char),  32'(msg_tbl[i]));
            chk($sformatf("a_run_busy%0d", i),  32'(busy_a),         32'd1);
            step();
        end
        chk("a_end_done",  32'(done_a),         32'd1);
        chk("a_end_busy",  32'(busy_a),         32'd0);
        chk("a_end_cnt",   32'(cnt_a),          32'd1);
        chk("a_end_char",  32'(if_a.out_char),  32'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (if_a.out_valid !== 1'b0) bad++;
            step();
        end
        chk("a_idle_after_done", 32'(bad), 32'd0);

        // ---------------- Test 2: random backpressure ---------------------
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("a_bp_cnt_cleared", 32'(cnt_a), 32'd0);
        chk("a_bp_done_clr",    32'(done_a), 32'd0);
        n = 0;
        hold_pend = 1'b0;
        held_char = 8'h00;
        budget = 0;
        while (n < 13 && budget < 500) begin
            if (hold_pend) begin
                chk("a_bp_hold_valid", 32'(if_a.out_valid), 32'd1);
                chk("a_bp_hold_char",  32'(if_a.out_char),  32'(held_char));
            end
            if_a.out_ready = ($urandom_range(0, 9) < 3);
            hold_pend = if_a.out_valid && !if_a.out_ready;
            held_char = if_a.out_char;
            if (if_a.out_valid && if_a.out_ready) begin
                chk($sformatf("a_bp_char%0d", n), 32'(if_a.out_char), 32'(msg_tbl[n]));
                n++;
            end
            step();
            budget++;
        end
        chk("a_bp_xfers", 32'(n), 32'd13);
        if_a.out_ready = 1'b1;
        step();
        chk("a_bp_done", 32'(done_a), 32'd1);
        chk("a_bp_cnt",  32'(cnt_a),  32'd1);

        // ---------------- Test 5: abort, restart, start while busy --------
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("a_ab_char%0d", i), 32'(if_a.out_char), 32'(msg_tbl[i]));
            step();
        end
        chk("a_ab_char3", 32'(if_a.out_char), 32'(msg_tbl[3]));
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("a_ab_valid", 32'(if_a.out_valid), 32'd0);
        chk("a_ab_busy",  32'(busy_a),         32'd0);
        chk("a_ab_done",  32'(done_a),         32'd0);
        chk("a_ab_char",  32'(if_a.out_char),  32'd0);
        repeat (3) step();
        chk("a_ab_stay_idle", 32'(if_a.out_valid), 32'd0);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("a_rs_valid", 32'(if_a.out_valid), 32'd1);
        chk("a_rs_char",  32'(if_a.out_char),  32'h48);
        chk("a_rs_cnt",   32'(cnt_a),          32'd0);
        step();
        step();
        chk("a_rs_char2", 32'(if_a.out_char), 32'(msg_tbl[2]));
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("a_busy_start_char", 32'(if_a.out_char), 32'(msg_tbl[3]));
        chk("a_busy_start_cnt",  32'(cnt_a),         32'd0);
        start_a = 1'b1;
        abort_a = 1'b1;
        step();
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("a_abort_wins", 32'(if_a.out_valid), 32'd0);

        // ---------------- Test 3: gaps and REPEAT=2 -----------------------
        rst_b = 1'b0;
        step();
        n = 0;
        last_cyc = 0;
        budget = 0;
        while (n < 26 && budget < 300) begin
            if (if_b.out_valid) begin
                chk($sformatf("b_char%0d", n), 32'(if_b.out_char), 32'(msg_tbl[n % 13]));
                chk($sformatf("b_cnt%0d", n),  32'(cnt_b),         32'(n / 13));
                if (n == 0) begin
                    chk("b_first_cycle", 32'(budget), 32'd0);
                end else if (n % 13 == 0) begin
                    chk($sformatf("b_mgap%0d", n), 32'(budget - last_cyc), 32'd6);
                end else begin
                    chk($sformatf("b_cgap%0d", n), 32'(budget - last_cyc), 32'd3);
                end
                last_cyc = budget;
                n++;
            end
            step();
            budget++;
        end
        chk("b_xfers", 32'(n),            32'd26);
        chk("b_done",  32'(done_b),       32'd1);
        chk("b_busy",  32'(busy_b),       32'd0);
        chk("b_cnt",   32'(cnt_b),        32'd2);
        chk("b_valid", 32'(if_b.out_valid), 32'd0);

        // ---------------- Test 4: endless single-char message -------------
        rst_c = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("c_valid%0d", i), 32'(if_c.out_valid), 32'd1);
            chk($sformatf("c_char%0d", i),  32'(if_c.out_char),  32'h55);
            chk($sformatf("c_cnt%0d", i),   32'(cnt_c),          32'((i > 15) ? 15 : i));
            chk($sformatf("c_done%0d", i),  32'(done_c),         32'd0);
            step();
        end

        // ---------------- Test 6: manual start, reset under backpressure --
        rst_d = 1'b0;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (if_d.out_valid !== 1'b0 || busy_d !== 1'b0) bad++;
        end
        chk("d_no_autostart", 32'(bad), 32'd0);
        start_d = 1'b1;
        step();
        start_d = 1'b0;
        chk("d_start_valid", 32'(if_d.out_valid), 32'd1);
        chk("d_start_char",  32'(if_d.out_char),  32'h48);
        step();
        step();
        chk("d_hold_valid", 32'(if_d.out_valid), 32'd1);
        chk("d_hold_char",  32'(if_d.out_char),  32'h48);
        rst_d = 1'b1;
        step();
        chk("d_rst_valid", 32'(if_d.out_valid), 32'd0);
        chk("d_rst_char",  32'(if_d.out_char),  32'd0);
        chk("d_rst_busy",  32'(busy_d),         32'd0);
        chk("d_rst_done",  32'(done_d),         32'd0);
        chk("d_rst_cnt",   32'(cnt_d),          32'd0);
        rst_d = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (if_d.out_valid !== 1'b0) bad++;
        end
        chk("d_no_autostart_after_rst", 32'(bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/osd_msg_source.md
Name: osd_msg_source

Overview:
Parametrised debug character-stream source that feeds a fixed message into a character sink, typically the out_char/out_valid/out_ready side of osd_dem_uart. The message, data width, repeat count and character/message pacing are set by parameters. It supports start, abort, repeat and completion status, so system-level benches and demo SoCs can exercise the UART DEM without hand-written counters.

Parameters:
- DATA_WIDTH, 8: width of one character.
- MSG_LEN, 13: characters per message; must be at least 1.
- MSG, "Hello World!\n" (13x8 bits): packed message of width MSG_LEN*DATA_WIDTH. Character i is MSG[(MSG_LEN-1-i)*DATA_WIDTH +: DATA_WIDTH], so character 0 is the MSB slice.
- REPEAT, 1: number of messages to send; 0 means repeat forever.
- CHAR_GAP, 0: idle cycles between characters within a message.
- MSG_GAP, 0: idle cycles between messages.
- AUTOSTART, 1: start sending automatically after reset with no start pulse.
- CNT_WIDTH, 16: width of msg_count.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  single-cycle pulse; begins a new run from IDLE or DONE
- abort  in  1  pulse; stops immediately and returns to IDLE
- out_char  out  DATA_WIDTH  current character
- out_valid  out  1  character valid
- out_ready  in  1  sink accepts character
- busy  out  1  run in progress
- done  out  1  run completed (sticky)
- msg_count  out  CNT_WIDTH  messages fully sent in this run

Interface: reset rst, synchronous, active-high; clock clk.

Behaviour:
- Reset values: out_valid=0, out_char=0, busy=0, done=0, msg_count=0, char index=0, state=IDLE. If AUTOSTART=1, state goes IDLE->SEND on the first cycle after rst deasserts, so out_valid=1 one cycle after release.
- States: IDLE, SEND, CGAP, MGAP, DONE.
- All outputs are decoded from registers. There is no combinational path from out_ready, start or abort to any output.
- Output decode:
  - out_valid = (state==SEND).
  - out_char = MSG[idx] while in SEND, otherwise 0.
  - busy = state in {SEND, CGAP, MGAP}.
  - done = (state==DONE).
- Handshake rules:
  - A transfer occurs in a cycle where out_valid && out_ready.
  - Once out_valid is high, it and out_char stay stable until the transfer; the only exceptions are abort and rst.
- On a transfer with idx < MSG_LEN-1:
  - idx increments.
  - Next state is CGAP if CHAR_GAP>0, otherwise SEND. With CHAR_GAP=0 the block sends back-to-back, one character per cycle.
- On a transfer with idx == MSG_LEN-1:
  - idx returns to 0 and msg_count increments, saturating at all-ones.
  - If REPEAT!=0 and the new msg_count==REPEAT, next state is DONE.
  - Otherwise next state is MGAP if MSG_GAP>0, else SEND.
  - MSG_LEN=1 works: every transfer is a message end.
- CGAP / MGAP timing:
  - A down-counter loaded on entry gives exactly CHAR_GAP (or MSG_GAP) cycles with out_valid=0 between the transfer cycle and the next valid cycle.
  - Counter width is $clog2(max(CHAR_GAP, MSG_GAP)+1), minimum 1.
- start:
  - In IDLE or DONE: clears msg_count and idx; SEND on the next cycle.
  - While busy: ignored.
- abort:
  - Highest priority below rst; next state is IDLE from any state.
  - If a transfer occurs in the same cycle, that character counts as delivered but idx and msg_count are not updated. The next start restarts at character 0.
  - done stays 0 after abort.
- start and abort in the same cycle: abort wins.
- rst mid-message, even with out_valid held high under backpressure: all outputs take their reset values on the next edge.
- REPEAT=0: done never asserts, and msg_count saturates rather than wrapping.

Decomposition:
- Package osd_msg_source_pkg holds the state enum typedef (msg_src_state_t) and a gap-counter width function.
- Single module; no sub-module is needed. The gap counter is inline.

Test Plan:
1. Defaults, out_ready=1 -> 13 consecutive valid cycles starting 1 cycle after reset: 0x48 65 6c 6c 6f 20 57 6f 72 6c 64 21 0a. Then done=1, busy=0, msg_count=1, and out_valid stays 0 for 100 cycles.
2. Defaults, out_ready random 30% -> identical 13-character sequence; out_char stable while valid && !ready; exactly one transfer per valid&&ready cycle.
3. CHAR_GAP=2, MSG_GAP=5, REPEAT=2, ready=1 -> 26 transfers; exactly 2 idle cycles between characters and 5 between messages; msg_count reaches 1 then 2; done after transfer 26.
4. REPEAT=0, MSG_LEN=1, MSG=8'h55, ready=1 -> 0x55 every cycle; msg_count increments each cycle; done never asserts; with CNT_WIDTH=4, msg_count saturates at 15.
5. abort on the cycle of the 4th transfer -> out_valid=0 and busy=0 next cycle; a later start produces 0x48 first with msg_count=0; start while busy has no effect.
6. AUTOSTART=0 -> no valid for 50 cycles until the start pulse. Then rst while valid&&!ready -> all outputs 0 next cycle, and no autostart afterwards.
